// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers
module pipe_ctrl #(
    parameter int LREG_W     = 5,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [LREG_W-1:0] id_rs1,
    input  logic [LREG_W-1:0] id_rs2,
    input  logic              id_src1_is_reg,
    input  logic              id_src2_is_reg,
    input  logic              ex_valid,
    input  logic [LREG_W-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_need_to_wb,
    input  logic              ex_is_muldiv,
    input  logic              ex_redirect,
    input  logic              mem_valid,
    input  logic              mem_is_load,
    input  logic              mem_is_store,
    input  logic              dmem_resp_valid,
    output logic              dmem_req_valid,
    output logic              ifu_redirect,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_stall,
    output logic              idex_flush,
    output logic              exmem_stall,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic              muldiv_busy
);

    typedef enum logic {M_IDLE, M_WAIT} mem_state_t;
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    mem_state_t       mem_state, mem_state_next;
    md_state_t        md_state, md_state_next;
    logic [CNT_W-1:0] md_cnt, md_cnt_next;
    logic             redirect_done, redirect_done_next;

    logic mem_req;
    logic mem_busy;
    logic md_start;
    logic load_use;
    logic redirect_fire;

    assign mem_req  = mem_valid & (mem_is_load | mem_is_store);
    assign mem_busy = ((mem_state == M_IDLE) & mem_req)
                    | ((mem_state == M_WAIT) & ~dmem_resp_valid);
    assign md_start = (md_state == MD_IDLE) & ex_valid & ex_is_muldiv;

    assign load_use = ex_valid & ex_is_load & ex_need_to_wb & (ex_rd != '0) & id_valid
                    & ((id_src1_is_reg & (id_rs1 == ex_rd)) | (id_src2_is_reg & (id_rs2 == ex_rd)));

    // A redirect waits out a memory stall so the IFU is steered exactly once.
    assign redirect_fire = ex_redirect & ex_valid & ~redirect_done & ~mem_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_state     <= M_IDLE;
            md_state      <= MD_IDLE;
            md_cnt        <= '0;
            redirect_done <= 1'b0;
        end else begin
            mem_state     <= mem_state_next;
            md_state      <= md_state_next;
            md_cnt        <= md_cnt_next;
            redirect_done <= redirect_done_next;
        end
    end

    // md_cnt counts the EX cycles still owed by the mul/div, the current one included.
    always_comb begin
        mem_state_next     = mem_state;
        md_state_next      = md_state;
        md_cnt_next        = md_cnt;
        redirect_done_next = redirect_done;

        case (mem_state)
            M_IDLE:  if (mem_req) mem_state_next = M_WAIT;
            M_WAIT:  if (dmem_resp_valid) mem_state_next = M_IDLE;
            default: mem_state_next = M_IDLE;
        endcase

        case (md_state)
            MD_IDLE: begin
                if (md_start) begin
                    md_cnt_next   = CNT_W'(MULDIV_LAT - 1);
                    md_state_next = (MULDIV_LAT > 2) ? MD_BUSY : MD_DONE;
                end
            end
            MD_BUSY: begin
                md_cnt_next = md_cnt - CNT_W'(1);
                if (md_cnt == CNT_W'(2)) md_state_next = MD_DONE;
            end
            MD_DONE: begin
                if (!idex_stall) begin
                    md_state_next = MD_IDLE;
                    md_cnt_next   = '0;
                end
            end
            default: begin
                md_state_next = MD_IDLE;
                md_cnt_next   = '0;
            end
        endcase

        if (!idex_stall)
            redirect_done_next = 1'b0;
        else if (redirect_fire)
            redirect_done_next = 1'b1;
    end

    always_comb begin
        dmem_req_valid = (mem_state == M_IDLE) & mem_req;
        muldiv_busy    = md_start | (md_state == MD_BUSY);
        ifu_redirect   = redirect_fire;

        pc_stall    = (mem_busy | muldiv_busy | load_use) & ~redirect_fire;
        ifid_stall  = mem_busy | muldiv_busy | (load_use & ~redirect_fire);
        idex_stall  = mem_busy | muldiv_busy;
        exmem_stall = mem_busy;

        // Flushes are masked by the same register's stall so a held value is never lost.
        ifid_flush  = redirect_fire & ~ifid_stall;
        idex_flush  = (redirect_fire | load_use) & ~idex_stall;
        exmem_flush = muldiv_busy & ~exmem_stall;
        memwb_flush = mem_busy;
    end

endmodule
